// File: rtl/mem_port_arb.sv
// ============================================================================
// Module   : mem_port_arb
// Function : Four-way round-robin arbiter onto one memory read/write port,
//            with an in-order tag FIFO that steers returned read data back
//            to the requester that issued the read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arb #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32,
  parameter int TAG_DEPTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_reset,        // synchronous, active-low
  input  logic [3:0]                   i_req,
  input  logic [3:0]                   i_req_we,
  input  logic [4*ADDR_W-1:0]          i_req_addr,
  input  logic [4*DATA_W-1:0]          i_req_wdata,
  output logic [3:0]                   o_gnt,
  output logic [3:0]                   o_rvalid,
  output logic [DATA_W-1:0]            o_rdata,
  output logic                         o_wr_en,
  output logic [ADDR_W-1:0]            o_wr_addr,
  output logic [DATA_W-1:0]            o_wr_data,
  output logic                         o_rd_en,
  output logic [ADDR_W-1:0]            o_rd_addr,
  input  logic                         i_wr_rdy,
  input  logic                         i_rd_rdy,
  input  logic                         i_rd_data_valid,
  input  logic [DATA_W-1:0]            i_rd_data,
  output logic [$clog2(TAG_DEPTH):0]   o_outstanding,
  output logic                         o_err
);

  localparam int c_PTR_W = $clog2(TAG_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [1:0]          r_ptr;
  logic [3:0]          r_gnt;
  logic [3:0]          r_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [c_CNT_W-1:0]  r_outstanding;
  logic                r_err;
  logic [1:0]          r_tag [TAG_DEPTH];
  logic [c_PTR_W-1:0]  r_wptr;
  logic [c_PTR_W-1:0]  r_rptr;

  logic [3:0]          w_elig;
  logic                w_rd_room;
  logic                w_found;
  logic [1:0]          w_win;
  logic                w_push;
  logic                w_pop;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_wdata;

  // A read may only issue while the tag FIFO has a free slot.
  assign w_rd_room = (r_outstanding < c_CNT_W'(TAG_DEPTH));

  // The requester granted last cycle still shows its old command while it
  // sees gnt, so it is masked for one cycle to avoid a double grant.
  for (genvar gi = 0; gi < 4; gi++) begin : g_elig
    assign w_elig[gi] = i_req[gi] & ~r_gnt[gi] &
                        (i_req_we[gi] ? i_wr_rdy : (i_rd_rdy & w_rd_room));
  end

  // Round-robin search: first eligible requester at ptr, ptr+1, ... (mod 4).
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && w_elig[r_ptr + 2'(k)]) begin
        w_found = 1'b1;
        w_win   = r_ptr + 2'(k);
      end
    end
  end

  assign w_win_addr  = i_req_addr[w_win*ADDR_W +: ADDR_W];
  assign w_win_wdata = i_req_wdata[w_win*DATA_W +: DATA_W];
  assign w_push      = w_found & ~i_req_we[w_win];
  // A return with nothing outstanding has no owner and is not popped.
  assign w_pop       = i_rd_data_valid & (r_outstanding != '0);

  // Grant, memory strobes and the held address/data fields.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_ptr     <= 2'd0;
      r_gnt     <= 4'd0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_gnt   <= w_found ? (4'b0001 << w_win) : 4'd0;
      r_wr_en <= w_found & i_req_we[w_win];
      r_rd_en <= w_push;
      if (w_found) begin
        r_ptr <= w_win + 2'd1;
        if (i_req_we[w_win]) begin
          r_wr_addr <= w_win_addr;
          r_wr_data <= w_win_wdata;
        end else begin
          r_rd_addr <= w_win_addr;
        end
      end
    end
  end

  // Tag FIFO pointers, occupancy count, read-return steering and sticky error.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_outstanding <= '0;
      r_rvalid      <= 4'd0;
      r_rdata       <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop) begin
        r_outstanding <= r_outstanding + 1'b1;
      end else if (!w_push && w_pop) begin
        r_outstanding <= r_outstanding - 1'b1;
      end
      r_rvalid <= w_pop ? (4'b0001 << r_tag[r_rptr]) : 4'd0;
      if (w_pop) r_rdata <= i_rd_data;
      if (i_rd_data_valid && (r_outstanding == '0)) r_err <= 1'b1;
    end
  end

  // Tag storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge i_clk) begin
    if (w_push) r_tag[r_wptr] <= w_win;
  end

  assign o_gnt         = r_gnt;
  assign o_rvalid      = r_rvalid;
  assign o_rdata       = r_rdata;
  assign o_wr_en       = r_wr_en;
  assign o_wr_addr     = r_wr_addr;
  assign o_wr_data     = r_wr_data;
  assign o_rd_en       = r_rd_en;
  assign o_rd_addr     = r_rd_addr;
  assign o_outstanding = r_outstanding;
  assign o_err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arb.sv
// ============================================================================
// Module   : tb_mem_port_arb
// Function : Self-checking bench for mem_port_arb: behavioural queue model
//            compared every cycle, directed scenarios, randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arb;

  localparam int ADDR_W    = 24;
  localparam int DATA_W    = 32;
  localparam int TAG_DEPTH = 8;
  localparam int CNT_W     = $clog2(TAG_DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [3:0]           req, req_we;
  logic [4*ADDR_W-1:0]  req_addr;
  logic [4*DATA_W-1:0]  req_wdata;
  logic                 wr_rdy, rd_rdy, rd_data_valid;
  logic [DATA_W-1:0]    rd_data;
  logic [3:0]           gnt, rvalid;
  logic [DATA_W-1:0]    rdata, wr_data;
  logic [ADDR_W-1:0]    wr_addr, rd_addr;
  logic                 wr_en, rd_en, err;
  logic [CNT_W-1:0]     outstanding;

  always #4 clk = ~clk;

  mem_port_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) dut (
    .i_clk(clk), .i_reset(reset_n), .i_req(req), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr),
    .i_wr_rdy(wr_rdy), .i_rd_rdy(rd_rdy),
    .i_rd_data_valid(rd_data_valid), .i_rd_data(rd_data),
    .o_outstanding(outstanding), .o_err(err)
  );

  // Reference model state: pointer, last winner, queue of owning requesters.
  int                m_ptr, m_prev;
  int                m_q[$];
  logic              m_err;
  logic [3:0]        e_gnt, e_rvalid;
  logic              e_wr_en, e_rd_en;
  logic [ADDR_W-1:0] e_wr_addr, e_rd_addr;
  logic [DATA_W-1:0] e_wr_data, e_rdata;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance the model by one clock from the inputs currently applied.
  task automatic model_eval();
    int win, idx, t;
    logic el;
    if (!reset_n) begin
      m_ptr = 0; m_prev = -1; m_q.delete(); m_err = 1'b0;
      e_gnt = 0; e_rvalid = 0; e_wr_en = 0; e_rd_en = 0;
      e_wr_addr = 0; e_wr_data = 0; e_rd_addr = 0; e_rdata = 0;
    end else begin
      win = -1;
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        el  = req[idx] && (idx != m_prev) &&
              (req_we[idx] ? wr_rdy : (rd_rdy && (m_q.size() < TAG_DEPTH)));
        if (win < 0 && el) win = idx;
      end
      e_rvalid = 0;
      if (rd_data_valid) begin
        if (m_q.size() > 0) begin
          t = m_q.pop_front();
          e_rvalid[t] = 1'b1;
          e_rdata = rd_data;
        end else begin
          m_err = 1'b1;
        end
      end
      e_gnt = 0; e_wr_en = 0; e_rd_en = 0;
      if (win >= 0) begin
        e_gnt[win] = 1'b1;
        m_ptr = (win + 1) % 4;
        if (req_we[win]) begin
          e_wr_en   = 1'b1;
          e_wr_addr = req_addr[win*ADDR_W +: ADDR_W];
          e_wr_data = req_wdata[win*DATA_W +: DATA_W];
        end else begin
          e_rd_en   = 1'b1;
          e_rd_addr = req_addr[win*ADDR_W +: ADDR_W];
          m_q.push_back(win);
        end
      end
      m_prev = win;
    end
  endtask

  // One clock: update model, then compare every output just after the edge.
  task automatic cycle();
    model_eval();
    @(posedge clk);
    #1;
    n_vec++;
    check("gnt", gnt, e_gnt);
    check("wr_en", wr_en, e_wr_en);
    check("rd_en", rd_en, e_rd_en);
    check("wr_addr", wr_addr, e_wr_addr);
    check("wr_data", wr_data, e_wr_data);
    check("rd_addr", rd_addr, e_rd_addr);
    check("rvalid", rvalid, e_rvalid);
    if (e_rvalid != 0) check("rdata", rdata, e_rdata);
    check("outstanding", outstanding, m_q.size());
    check("err", err, m_err);
  endtask

  task automatic idle();
    req = 0; req_we = 0; rd_data_valid = 0; rd_data = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; idle(); wr_rdy = 1'b1; rd_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*ADDR_W +: ADDR_W]   = ADDR_W'(32'h100 + i);
      req_wdata[i*DATA_W +: DATA_W]  = 32'hD0D0_0000 + i;
    end

    // Reset held with every requester asking.
    req = 4'hF; req_we = 4'hF;
    for (int c = 0; c < 2; c++) begin
      cycle();
      check("reset_gnt", gnt, 4'h0);
      check("reset_outstanding", outstanding, 0);
    end
    reset_n = 1'b1;

    // Continuous writes from all four: strict 0,1,2,3 rotation.
    for (int c = 0; c < 8; c++) begin
      cycle();
      check("rr_gnt", gnt, 4'b0001 << (c % 4));
      check("rr_wr_addr", wr_addr, 24'h100 + (c % 4));
    end

    // Read steering: requester 2 then requester 0.
    do_reset(); idle();
    req = 4'b0100; req_addr[2*ADDR_W +: ADDR_W] = 24'h10; cycle();
    check("steer_rd_addr_2", rd_addr, 24'h10);
    req = 4'b0001; req_addr[0 +: ADDR_W] = 24'h20; cycle();
    check("steer_rd_addr_0", rd_addr, 24'h20);
    idle(); rd_data_valid = 1'b1; rd_data = 32'hAAAA_0000; cycle();
    check("steer_rvalid_2", rvalid, 4'b0100);
    check("steer_rdata_2", rdata, 32'hAAAA_0000);
    rd_data = 32'hBBBB_0000; cycle();
    check("steer_rvalid_0", rvalid, 4'b0001);
    check("steer_rdata_0", rdata, 32'hBBBB_0000);
    idle(); cycle();

    // Backpressure at full tag FIFO.
    do_reset(); idle();
    req = 4'hF; req_we = 4'h0;
    for (int c = 0; c < 8; c++) cycle();
    check("bp_outstanding_full", outstanding, 8);
    req_we = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("bp_no_read", rd_en, 1'b0);
      check("bp_write_gnt", gnt, (c % 2 == 0) ? 4'b0010 : 4'b0000);
    end
    req = 4'b1101; req_we = 4'h0; rd_data_valid = 1'b1; cycle();
    check("bp_pop_outstanding", outstanding, 7);
    check("bp_pop_rvalid", rvalid, 4'b0001);
    rd_data_valid = 1'b0; cycle();
    check("bp_refill_rd_en", rd_en, 1'b1);
    check("bp_refill_outstanding", outstanding, 8);
    cycle();
    check("bp_blocked_again", rd_en, 1'b0);

    // Ready gating: reads held off, writes still flow.
    do_reset(); idle();
    rd_rdy = 1'b0; req = 4'b1001; req_we = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("gate_gnt", gnt, (c % 2 == 0) ? 4'b1000 : 4'b0000);
    end
    rd_rdy = 1'b1; cycle();
    check("gate_read_after_rdy", gnt, 4'b0001);
    idle(); cycle();

    // Randomized traffic; returns only while something is outstanding.
    do_reset(); idle();
    for (int c = 0; c < 3000; c++) begin
      req    = 4'($urandom);
      req_we = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        if ($urandom_range(0, 3) == 0) req_wdata[i*DATA_W +: DATA_W] = $urandom;
      end
      wr_rdy = ($urandom_range(0, 99) < 80);
      rd_rdy = ($urandom_range(0, 99) < 80);
      rd_data_valid = (m_q.size() > 0) && ($urandom_range(0, 99) < 40);
      rd_data = $urandom;
      cycle();
    end
    check("random_no_err", err, 1'b0);

    // Reads in flight across reset: late returns flag an error.
    idle(); wr_rdy = 1'b1; rd_rdy = 1'b1; do_reset(); idle();
    req = 4'b0111;
    for (int c = 0; c < 3; c++) cycle();
    check("err_outstanding_3", outstanding, 3);
    idle(); do_reset();
    rd_data_valid = 1'b1; rd_data = 32'h1234_5678;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("err_no_rvalid", rvalid, 4'h0);
    end
    idle(); cycle();
    check("err_sticky", err, 1'b1);
    check("err_outstanding_0", outstanding, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
